// File: rtl/hazard_ctrl.sv
// Stall/flush side of hazard resolution for the 5-stage core: load-use bubbles,
// taken-branch squash, mul/div freeze with watchdog, and saturating perf counters.
module hazard_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic             ex_branch_taken,
  input  logic             ex_md_start,
  input  logic             md_done,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             md_busy,
  output logic             md_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WD_W = $clog2(MD_TIMEOUT + 1);

  typedef enum logic {RUN, MD_WAIT} state_e;

  state_e           state_q, state_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             md_error_q, md_error_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             flush_inc;
  logic             load_use;

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign load_use = ex_mem_read && ex_reg_write && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (ex_rd == id_rs1)) ||
                     (id_use_rs2 && (ex_rd == id_rs2)));

  always_comb begin
    state_d      = state_q;
    wd_d         = wd_q;
    md_error_d   = md_error_q;
    flush_inc    = 1'b0;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    md_busy      = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_md_start && !md_done) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_stall  = 1'b1;
          ex_mem_flush = 1'b1;
          state_d      = MD_WAIT;
          wd_d         = WD_W'(1);
        end else if (ex_md_start) begin
          // single-cycle completion: nothing to hold
        end else if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          flush_inc   = 1'b1;
        end else if (load_use) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end
      end
      MD_WAIT: begin
        md_busy = 1'b1;
        if (md_done) begin
          state_d = RUN;
          wd_d    = '0;
        end else if (wd_q == WD_W'(MD_TIMEOUT)) begin
          // watchdog: release the pipe as if the result arrived, flag it
          md_error_d = 1'b1;
          state_d    = RUN;
          wd_d       = '0;
        end else begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_stall  = 1'b1;
          ex_mem_flush = 1'b1;
          wd_d         = wd_q + WD_W'(1);
        end
      end
      default: state_d = RUN;
    endcase

    stall_cnt_d = stall_cnt_q;
    if (pc_stall && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    flush_cnt_d = flush_cnt_q;
    if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wd_q        <= '0;
      md_error_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      md_error_q  <= md_error_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign md_error  = md_error_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage RISC-V core. It is the stall/flush side of hazard resolution and complements the forwarding unit.
- Detects load-use RAW hazards that forwarding cannot cover.
- Squashes wrong-path instructions on a taken branch or jump.
- Freezes the front of the pipeline while a multi-cycle mul/div unit in EX is busy, with a watchdog timeout.
- Keeps saturating stall and flush performance counters.

Parameters:
MD_TIMEOUT, 64, max cycles spent in MD_WAIT before forced exit and error flag
CNT_W, 32, width of performance counters

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
id_rs1  in  5  rs1 of instruction in ID
id_rs2  in  5  rs2 of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  rd of instruction in EX (ID/EX register)
ex_mem_read  in  1  EX instruction is a load
ex_reg_write  in  1  EX instruction writes rd
ex_branch_taken  in  1  EX resolved taken branch/jump (PC redirect)
ex_md_start  in  1  EX holds a valid multi-cycle mul/div op
md_done  in  1  mul/div result valid this cycle
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID register
if_id_flush  out  1  clear IF/ID to NOP
id_ex_stall  out  1  hold ID/EX register
id_ex_flush  out  1  clear ID/EX to NOP (bubble)
ex_mem_flush  out  1  load bubble into EX/MEM
md_busy  out  1  state == MD_WAIT
md_error  out  1  sticky: watchdog expired
stall_cnt  out  CNT_W  cycles with pc_stall=1
flush_cnt  out  CNT_W  taken-branch flush events

Behaviour:
- Clocking and reset: one clock domain, clk. rst is synchronous and active-high.
- Reset state: state=RUN, wd counter=0, md_error=0, stall_cnt=0, flush_cnt=0.
- Control outputs are combinational from state and inputs, with no added latency. With all inputs 0 they are all 0.

Hazard terms:
- load_use = ex_mem_read & ex_reg_write & ex_rd!=0 & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)).
- x0 never causes a hazard.

FSM states: RUN, MD_WAIT.

RUN, evaluated in priority order:
1. ex_md_start & !md_done:
   - pc_stall = if_id_stall = id_ex_stall = ex_mem_flush = 1.
   - next state MD_WAIT, wd <= 1.
   - Other hazard terms are ignored this cycle.
2. ex_md_start & md_done: single-cycle completion, no stall, stay RUN.
3. ex_branch_taken:
   - if_id_flush = id_ex_flush = 1; pc_stall = 0, so PC loads the target.
   - flush_cnt increments.
   - Branch overrides load_use, because the ID instruction is wrong-path.
4. load_use:
   - pc_stall = if_id_stall = 1, id_ex_flush = 1.
   - This is exactly one bubble: the next cycle the load is in MEM and load_use deasserts naturally.
5. Otherwise all control outputs are 0.

MD_WAIT:
- md_busy = 1.
- ex_branch_taken and load_use are ignored, because the EX slot is occupied by the mul/div op.
- md_done = 0:
  - pc_stall = if_id_stall = id_ex_stall = ex_mem_flush = 1.
  - wd increments.
- md_done = 1:
  - All stall/flush outputs are 0, so the result advances into EX/MEM.
  - Next state RUN, wd <= 0.
- Watchdog: if wd == MD_TIMEOUT and md_done = 0:
  - md_error <= 1 (sticky until rst).
  - Next state RUN, with outputs as in the md_done=1 case that cycle.

Counters:
- stall_cnt increments every cycle in which pc_stall = 1.
- Both counters saturate at all-ones; there is no wrap.

Reset mid-operation: rst in MD_WAIT forces RUN next cycle, clears the counters and md_error, and all outputs are 0 in the following cycle.

Simultaneous events:
- ex_md_start together with ex_branch_taken: mul/div wins, and the branch is not counted.
- ex_md_start is level-sensitive only in RUN.

Test Plan:
- Load-use: ex_mem_read=1, ex_reg_write=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> pc_stall=if_id_stall=id_ex_flush=1 for one cycle; stall_cnt=1.
- x0 and unused-operand check: ex_rd=0 matching id_rs1=0 -> no stall. Separately, ex_rd=7, id_rs2=7, id_use_rs2=0 -> no stall.
- Branch over load-use: ex_branch_taken=1 with load_use true -> if_id_flush=id_ex_flush=1, pc_stall=0; flush_cnt=1, stall_cnt unchanged.
- Mul/div, 4-cycle: ex_md_start=1, md_done asserted on the 4th cycle -> pc_stall/id_ex_stall/ex_mem_flush high for 3 cycles, md_busy high for cycles 2-4, outputs 0 in the done cycle; stall_cnt=3.
- Watchdog: MD_TIMEOUT=8, md_done never asserts -> exit to RUN after wd reaches 8, md_error=1 and held until rst.
- Reset in MD_WAIT: rst=1 during the 2nd wait cycle -> next cycle md_busy=0, stall_cnt=0, all controls 0.
